// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO register file and its multiply/divide engine.
package hilo_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Write priority: an engine commit (DONE, or a single-cycle multiply) beats an
  // MTHI/MTLO in M on the same edge, because the M-stage instruction is older.

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// Pipeline-side bundle for muldiv_hilo: E-stage start, M-stage HI/LO writes, stall and HI/LO read.
interface muldiv_hilo_if #(parameter int WIDTH = 32);
  logic             flushE;
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             hilowriteM;
  logic             hilosrcM;
  logic [WIDTH-1:0] wdataM;
  logic             stallE;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output flushE, startE, opE, srcaE, srcbE, hilowriteM, hilosrcM, wdataM,
    input  stallE, hi_o, lo_o
  );

  modport slave (
    input  flushE, startE, opE, srcaE, srcbE, hilowriteM, hilosrcM, wdataM,
    output stallE, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_hilo_div_core.sv
// Unsigned restoring divider: load latches operands, each step asserts one quotient bit.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;

  // Trial subtraction; a zero divisor always succeeds, giving all-ones / dividend.
  always_comb begin
    shifted_s = {rem_r, quo_r[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_r};
  end

  // Partial remainder, quotient/dividend shift register and latched divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
    end else if (load) begin
      rem_r <= '0;
      quo_r <= dividend;
      dvs_r <= divisor;
    end else if (step) begin
      if (!diff_s[WIDTH]) begin
        rem_r <= diff_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
      dvs_r <= dvs_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO registers with a multi-cycle divider and a multiply that is single-cycle by
// default or an iterative shift-add when MULDIV_ITER_MUL_EN is defined.
module muldiv_hilo
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_hilo_if.slave bus
);

  localparam int             CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  md_state_e        state_r;
  md_state_e        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             is_div_s;
  logic             is_signed_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             start_run_s;
  logic             load_s;
  logic             stall_s;
  logic             step_s;
  logic             commit_run_s;
  logic             commit_mul_s;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] div_lo_s;
  logic [WIDTH-1:0] div_hi_s;
  logic [2*WIDTH-1:0] prod_s;
  logic             eng_wr_s;
  logic [WIDTH-1:0] eng_hi_s;
  logic [WIDTH-1:0] eng_lo_s;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  // Operand decode: magnitudes and signs for the signed ops, raw values otherwise.
  always_comb begin
    is_div_s    = op_is_div(bus.opE);
    is_signed_s = op_is_signed(bus.opE);
    sign_a_s    = is_signed_s & bus.srcaE[WIDTH-1];
    sign_b_s    = is_signed_s & bus.srcbE[WIDTH-1];
    if (sign_a_s) mag_a_s = neg_w(bus.srcaE);
    else          mag_a_s = bus.srcaE;
    if (sign_b_s) mag_b_s = neg_w(bus.srcbE);
    else          mag_b_s = bus.srcbE;
`ifdef MULDIV_ITER_MUL_EN
    start_run_s = bus.startE & ~bus.flushE;
`else
    start_run_s = bus.startE & ~bus.flushE & is_div_s;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= MD_IDLE;
    else      state_r <= state_nxt_s;
  end

  // FSM next state; a flush in RUN or DONE abandons the operation.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MD_IDLE: begin
        if (start_run_s) state_nxt_s = MD_RUN;
        else             state_nxt_s = MD_IDLE;
      end
      MD_RUN: begin
        if (bus.flushE)               state_nxt_s = MD_IDLE;
        else if (cnt_r == LAST_STEP)  state_nxt_s = MD_DONE;
        else                          state_nxt_s = MD_RUN;
      end
      MD_DONE: state_nxt_s = MD_IDLE;
      default: state_nxt_s = MD_IDLE;
    endcase
  end

  // FSM outputs: stall, iteration enable and commit strobes.
  always_comb begin
    stall_s      = 1'b0;
    step_s       = 1'b0;
    commit_run_s = 1'b0;
    commit_mul_s = 1'b0;
    case (state_r)
      MD_IDLE: begin
        stall_s = start_run_s;
`ifdef MULDIV_ITER_MUL_EN
        commit_mul_s = 1'b0;
`else
        commit_mul_s = bus.startE & ~bus.flushE & ~is_div_s;
`endif
      end
      MD_RUN: begin
        stall_s = ~bus.flushE;
        step_s  = ~bus.flushE;
      end
      MD_DONE: commit_run_s = ~bus.flushE;
      default: begin
        stall_s      = 1'b0;
        commit_run_s = 1'b0;
      end
    endcase
  end

  assign load_s = (state_r == MD_IDLE) & start_run_s;

  // Iteration counter; holds at the last step instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt_r <= '0;
    else if (step_s && (cnt_r != LAST_STEP))   cnt_r <= cnt_r + CNT_W'(1);
    else if (step_s)                           cnt_r <= cnt_r;
    else                                       cnt_r <= '0;
  end

  // Result sign fixes captured at start: quotient/product by sign mismatch, remainder by dividend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (load_s) begin
      neg_q_r <= sign_a_s ^ sign_b_s;
      neg_r_r <= sign_a_s;
    end else begin
      neg_q_r <= neg_q_r;
      neg_r_r <= neg_r_r;
    end
  end

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .rst_n     (rst),
    .load      (load_s),
    .step      (step_s),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Sign-corrected divide results.
  always_comb begin
    if (neg_q_r) div_lo_s = neg_w(quo_s);
    else         div_lo_s = quo_s;
    if (neg_r_r) div_hi_s = neg_w(rem_s);
    else         div_hi_s = rem_s;
  end

`ifdef MULDIV_ITER_MUL_EN
  logic             mul_r;
  logic [WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH:0]   sum_s;

  // One shift-add step: conditionally add the multiplicand into the upper half.
  always_comb begin
    if (acc_r[0]) sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    else          sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
  end

  // Iterative multiplier state: op kind, multiplicand and product/multiplier accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_r   <= 1'b0;
      mcand_r <= '0;
      acc_r   <= '0;
    end else if (load_s) begin
      mul_r   <= ~is_div_s;
      mcand_r <= mag_a_s;
      acc_r   <= {{WIDTH{1'b0}}, mag_b_s};
    end else if (step_s && mul_r) begin
      acc_r   <= {sum_s, acc_r[WIDTH-1:1]};
    end else begin
      acc_r   <= acc_r;
    end
  end

  // Engine write-back selection for the iterative build.
  always_comb begin
    if (neg_q_r) prod_s = neg_2w(acc_r);
    else         prod_s = acc_r;
    eng_wr_s = commit_run_s;
    if (mul_r) begin
      eng_hi_s = prod_s[2*WIDTH-1:WIDTH];
      eng_lo_s = prod_s[WIDTH-1:0];
    end else begin
      eng_hi_s = div_hi_s;
      eng_lo_s = div_lo_s;
    end
  end
`else
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;

  // Single-cycle multiply on sign- or zero-extended operands, then write-back selection.
  always_comb begin
    ext_a_s  = {{WIDTH{sign_a_s}}, bus.srcaE};
    ext_b_s  = {{WIDTH{sign_b_s}}, bus.srcbE};
    prod_s   = ext_a_s * ext_b_s;
    eng_wr_s = commit_run_s | commit_mul_s;
    if (commit_run_s) begin
      eng_hi_s = div_hi_s;
      eng_lo_s = div_lo_s;
    end else begin
      eng_hi_s = prod_s[2*WIDTH-1:WIDTH];
      eng_lo_s = prod_s[WIDTH-1:0];
    end
  end
`endif

  // HI/LO registers: engine commit first, otherwise the M-stage write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (eng_wr_s) begin
      hi_r <= eng_hi_s;
      lo_r <= eng_lo_s;
    end else if (bus.hilowriteM) begin
      if (bus.hilosrcM) hi_r <= bus.wdataM;
      else              lo_r <= bus.wdataM;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign bus.stallE = stall_s;
  assign bus.hi_o   = hi_r;
  assign bus.lo_o   = lo_r;

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- HI/LO register file plus multi-cycle multiply/divide engine.
- Consumes the E-stage mult/div start, the M-stage hilowrite/hilosrc controls and flushE.
- Returns stallE to the hazard logic.
- Sits beside the E/M datapath and supplies HI/LO to the M-stage read mux.

Parameters:
- WIDTH, 32, operand/HI/LO width. The divide takes WIDTH iterations.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flushE  in  1  E stage flushed; cancels any running operation
- startE  in  1  mult/div instruction valid in E
- opE  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- srcaE  in  WIDTH  rs operand (multiplicand / dividend)
- srcbE  in  WIDTH  rt operand (multiplier / divisor)
- hilowriteM  in  1  MTHI/MTLO write in M
- hilosrcM  in  1  1=write HI, 0=write LO
- wdataM  in  WIDTH  MTHI/MTLO data
- stallE  out  1  hold F/D/E stages
- hi_o  out  WIDTH  current HI
- lo_o  out  WIDTH  current LO

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, hi_o=0, lo_o=0, stallE=0. All partial results are cleared. Reset mid-operation abandons the operation.
- States are IDLE, RUN, DONE.
- IDLE, startE=1, opE is DIV/DIVU, flushE=0:
  - Latch |a|, |b| (or raw values for DIVU) and the result signs.
  - Go to RUN with counter=0.
  - stallE=1 combinationally in this cycle.
- RUN:
  - One restoring-division step per cycle, counter+1.
  - stallE=1.
  - When counter=WIDTH-1, go to DONE. Steps occupy cycles T+1..T+WIDTH.
- DONE (cycle T+WIDTH+1):
  - stallE=0.
  - Sign-corrected quotient goes to LO and remainder to HI, both at the closing edge.
  - Go to IDLE.
  - startE is ignored in DONE, because the same instruction is still in E.
  - Total residency in E: WIDTH+2 cycles, 34 for the default.
- Signed divide: the quotient is negated when the operand signs differ. The remainder takes the dividend's sign.
- Divide by zero is deterministic. Unsigned: LO=all ones, HI=dividend. Signed: the same values computed on magnitudes, then sign-corrected per the rule above.
- Multiply (feature off): IDLE with startE and MULT/MULTU writes the 2*WIDTH product at the closing edge of the same cycle (HI=upper, LO=lower). stallE=0 and the state stays IDLE.
- flushE=1 in RUN or DONE: go to IDLE with no HI/LO update. stallE drops in that same cycle. flushE with startE in IDLE: nothing starts.
- M-stage write: when hilowriteM=1, the selected register gets wdataM at the edge.
- Simultaneous M-write and engine commit (DONE or single-cycle mult): the engine result wins on the registers it writes. The M-stage instruction is older.
- hi_o/lo_o are plain register outputs with no bypass. M-stage read forwarding is handled outside this block.
- Counter width is clog2(WIDTH). It never wraps, because exit happens at WIDTH-1.

Optional Feature:
- Macro: MULDIV_ITER_MUL_EN.
- Defined: MULT/MULTU also use RUN with a WIDTH-step shift-add on magnitudes and sign-fix at DONE. Stall and flush timing are identical to divide.
- Undefined: single-cycle multiply as above, and no multiply datapath in RUN.

Decomposition:
- Shared package hilo_pkg holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - state encoding MD_IDLE/MD_RUN/MD_DONE
  - the DONE-over-M write-priority note as a constant comment
- One sub-module, div_core: the iterative restoring divider. It covers remainder/quotient shift registers and one step per enable, with no sign handling.
- Top level owns the FSM, the sign fix, the HI/LO registers and the multiply.

Test Plan:
- DIVU 100/7 at cycle T:
  - stallE high T..T+32, low at T+33.
  - After the edge: LO=14, HI=2.
- DIV -7/2 (0xFFFFFFF9, 2): LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULT vs MULTU with 0xFFFFFFFF×2:
  - Signed: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Unsigned: HI=0x00000001, LO=0xFFFFFFFE.
  - Feature off: both take 0 stall cycles.
  - Feature on: both take 33 stall cycles.
- DIVU 9/0: LO=0xFFFFFFFF, HI=0x00000009, with normal 34-cycle timing.
- flushE at iteration 10 of DIV with HI=0x11, LO=0x22 preloaded via MTHI/MTLO:
  - stallE=0 that cycle, state IDLE.
  - HI/LO stay 0x11/0x22.
- MTHI (wdataM=0xAAAA) coinciding with the DONE cycle of DIVU 20/3: HI=2 and LO=6 (engine wins).
- rst pulsed low mid-RUN: outputs 0 asynchronously; a new DIVU after release completes correctly.
